otter_fetch_window: RTL

Parametrised multi-issue fetch front end for the pipelined OTTER. It owns the fetch PC and issues one window-aligned instruction-memory read per cycle, INSTR_WINDOW instructions wide. It presents the returned window to decode through a valid/ready handshake with a per-slot valid mask. It supports branch/jump redirect, decode back-pressure and an accepted-instruction counter. It replaces the single PC register plus free-running decode PC shift at the head of the pipeline.

---
 rtl/otter_fetch_window_if.sv | 28 ++
 rtl/otter_fetch_window.sv | 106 ++++++++++
 2 files changed

// File: rtl/otter_fetch_window_if.sv
// Fetch-front-end bundle: redirect input, instruction-memory port and decode handshake.
// The master modport is the fetch unit; the slave modport is memory, decode and branch logic.
interface otter_fetch_window_if #(
  parameter int INSTR_WINDOW = 2,
  parameter int CNT_W        = 32
);
  logic                      REDIRECT_VALID;
  logic [31:0]               REDIRECT_PC;
  logic                      IMEM_EN;
  logic [31:0]               IMEM_ADDR;
  logic [32*INSTR_WINDOW-1:0] IMEM_RDATA;
  logic                      DEC_VALID;
  logic                      DEC_READY;
  logic [32*INSTR_WINDOW-1:0] DEC_PC;
  logic [32*INSTR_WINDOW-1:0] DEC_INSTR;
  logic [INSTR_WINDOW-1:0]   DEC_MASK;
  logic [CNT_W-1:0]          FETCH_COUNT;

  modport master (
    input  REDIRECT_VALID, REDIRECT_PC, IMEM_RDATA, DEC_READY,
    output IMEM_EN, IMEM_ADDR, DEC_VALID, DEC_PC, DEC_INSTR, DEC_MASK, FETCH_COUNT
  );

  modport slave (
    output REDIRECT_VALID, REDIRECT_PC, IMEM_RDATA, DEC_READY,
    input  IMEM_EN, IMEM_ADDR, DEC_VALID, DEC_PC, DEC_INSTR, DEC_MASK, FETCH_COUNT
  );
endinterface

// File: rtl/otter_fetch_window.sv
// Window-aligned fetch: one IMEM read per cycle, window reaches decode one cycle later.
// Redirect beats advance; decode back-pressure freezes the window and stops IMEM reads.
module otter_fetch_window #(
  parameter int          INSTR_WINDOW = 2,
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input logic                 CLK,
  input logic                 EXT_RESET_N,
  otter_fetch_window_if.master bus
);

  localparam int          WB       = 4 * INSTR_WINDOW;
  localparam logic [31:0] OFS_MASK = 32'(WB - 1);

  function automatic logic [31:0] base_of(input logic [31:0] x);
    return x & ~OFS_MASK;
  endfunction

  // Slots below the entry slot of the target hold instructions we must not issue.
  function automatic logic [INSTR_WINDOW-1:0] mask_of(input logic [31:0] x);
    logic [31:0]             slot;
    logic [INSTR_WINDOW-1:0] m;
    slot = (x & OFS_MASK) >> 2;
    m    = '0;
    for (int i = 0; i < INSTR_WINDOW; i++) begin
      m[i] = (32'(i) >= slot);
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [INSTR_WINDOW-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < INSTR_WINDOW; i++) begin
      n = n + CNT_W'(m[i]);
    end
    return n;
  endfunction

  logic [31:0]             fetch_pc_q, fetch_pc_d;
  logic                    r_valid_q,  r_valid_d;
  logic [31:0]             r_base_q,   r_base_d;
  logic [INSTR_WINDOW-1:0] r_mask_q,   r_mask_d;
  logic [CNT_W-1:0]        count_q,    count_d;

  logic        advance;
  logic        issue;
  logic        xfer;
  logic [31:0] issue_pc;

  always_comb begin
    advance    = !r_valid_q || bus.DEC_READY;
    issue      = bus.REDIRECT_VALID || advance;
    xfer       = r_valid_q && bus.DEC_READY && !bus.REDIRECT_VALID;
    issue_pc   = bus.REDIRECT_VALID ? bus.REDIRECT_PC : fetch_pc_q;

    fetch_pc_d = fetch_pc_q;
    r_valid_d  = r_valid_q;
    r_base_d   = r_base_q;
    r_mask_d   = r_mask_q;
    count_d    = count_q;

    // A redirect overwrites the R stage, so the window it replaces is never counted.
    if (issue) begin
      r_valid_d  = 1'b1;
      r_base_d   = base_of(issue_pc);
      r_mask_d   = mask_of(issue_pc);
      fetch_pc_d = base_of(issue_pc) + 32'(WB);
    end
    if (xfer) begin
      count_d = count_q + popcnt(r_mask_q);
    end
  end

  always_ff @(posedge CLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      fetch_pc_q <= RESET_VEC;
      r_valid_q  <= 1'b0;
      r_base_q   <= '0;
      r_mask_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      r_valid_q  <= r_valid_d;
      r_base_q   <= r_base_d;
      r_mask_q   <= r_mask_d;
      count_q    <= count_d;
    end
  end

  // While held in reset no read is launched and the address parks on the reset vector.
  assign bus.IMEM_EN   = EXT_RESET_N && issue;
  assign bus.IMEM_ADDR = !EXT_RESET_N ? base_of(fetch_pc_q) :
                         issue        ? base_of(issue_pc)   : r_base_q;

  assign bus.DEC_VALID   = r_valid_q;
  assign bus.DEC_MASK    = r_valid_q ? r_mask_q : '0;
  assign bus.DEC_INSTR   = bus.IMEM_RDATA;
  assign bus.FETCH_COUNT = count_q;

  for (genvar i = 0; i < INSTR_WINDOW; i++) begin : g_pc
    assign bus.DEC_PC[32*i +: 32] = r_valid_q ? (r_base_q + 32'(4 * i)) : 32'h0;
  end

endmodule
